instr_fetch: RTL and testbench

Instruction fetch stage for the SincereMicro core. It owns the program counter, drives the address into the combinational program memory, and captures the returned 46-bit line into an instruction register. It splits the captured line into decoded fields and hands them downstream to execute through a valid/ready handshake. It also supports branch redirects and halts on a HALT opcode.

---
 rtl/sm_pkg.sv | 27 ++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_pkg.sv
// Shared SincereMicro definitions: program line layout, opcodes, fetch state.
package sm_pkg;

    localparam int LINE_W   = 46;

    localparam int ECHO_MSB = 45;
    localparam int ECHO_LSB = 42;
    localparam int MODE_MSB = 41;
    localparam int MODE_LSB = 40;
    localparam int OP_MSB   = 39;
    localparam int OP_LSB   = 36;
    localparam int A_MSB    = 35;
    localparam int A_LSB    = 24;
    localparam int B_MSB    = 23;
    localparam int B_LSB    = 12;
    localparam int C_MSB    = 11;
    localparam int C_LSB    = 0;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, registers the memory line into decoded out_* fields.
// Latency 1 cycle addr->out_*; out_* hold while out_valid && !out_ready; redirect overrides stall.
// FETCH_ADDR_CHECK_EN: flag addr_err when the line's address echo differs from the PC.
module instr_fetch
    import sm_pkg::*;
#(
    parameter int unsigned PROG_LEN = 7,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] line,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [1:0]        out_mode,
    output logic [3:0]        out_op,
    output logic [11:0]       out_a,
    output logic [11:0]       out_b,
    output logic [11:0]       out_c,
    output logic              addr_err
);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic              valid_d;
    logic              err_d;
    logic              capture;
    logic              load;
    logic              pc_wrap;
    logic              redirect_oor;

    assign addr         = pc;
    assign load         = (state == RUN) && (!out_valid || out_ready);
    assign pc_wrap      = (pc == ADDR_W'(PROG_LEN - 1));
    assign redirect_oor = (32'(redirect_addr) >= PROG_LEN);

`ifdef FETCH_ADDR_CHECK_EN
    logic echo_mismatch;
    assign echo_mismatch = (32'(line[ECHO_MSB:ECHO_LSB]) != 32'(pc));
`else
    logic unused_echo;
    assign unused_echo = ^line[ECHO_MSB:ECHO_LSB];
`endif

    always_comb begin
        state_d = state;
        pc_d    = pc;
        valid_d = out_valid;
        err_d   = addr_err;
        capture = 1'b0;
        // Redirect squashes whatever is presented, even if it is a stalled HALT.
        if (redirect_valid) begin
            valid_d = 1'b0;
            state_d = RUN;
            if (redirect_oor) begin
                pc_d  = '0;
                err_d = 1'b1;
            end else begin
                pc_d = redirect_addr;
            end
        end else if (load) begin
            capture = 1'b1;
            valid_d = 1'b1;
            pc_d    = pc_wrap ? '0 : pc + 1'b1;
            if (line[OP_MSB:OP_LSB] == OPC_HALT) begin
                state_d = HALTED;
            end
`ifdef FETCH_ADDR_CHECK_EN
            if (echo_mismatch) begin
                err_d = 1'b1;
            end
`endif
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            pc        <= '0;
            out_valid <= 1'b0;
            addr_err  <= 1'b0;
            out_pc    <= '0;
            out_mode  <= '0;
            out_op    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            out_valid <= valid_d;
            addr_err  <= err_d;
            if (capture) begin
                out_pc   <= pc;
                out_mode <= line[MODE_MSB:MODE_LSB];
                out_op   <= line[OP_MSB:OP_LSB];
                out_a    <= line[A_MSB:A_LSB];
                out_b    <= line[B_MSB:B_LSB];
                out_c    <= line[C_MSB:C_LSB];
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a spec-level model.
module tb_instr_fetch;

    localparam int PL = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  addr;
    logic [45:0] line;
    logic        redirect_valid = 1'b0;
    logic [3:0]  redirect_addr = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_pc;
    logic [1:0]  out_mode;
    logic [3:0]  out_op;
    logic [11:0] out_a, out_b, out_c;
    logic        addr_err;

    logic [45:0] mem [16];
    assign line = mem[addr];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what execute should see, derived from the fetch rules.
    int          m_pc;
    int          m_opc;
    bit          m_v, m_halt, m_err;
    logic [45:0] m_word;

    instr_fetch #(.PROG_LEN(PL), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .line(line),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_mode(out_mode), .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .out_c(out_c), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [45:0] mk(input int idx, input logic [3:0] op);
        logic [3:0] e;
        e = idx[3:0];
        return {e, e[1:0], op, 12'($urandom), 12'($urandom), 12'($urandom)};
    endfunction

    function automatic logic [3:0] op_for(input int i);
        case (i)
            0: return 4'h1;
            1: return 4'h0;
            2: return 4'h9;
            3: return 4'h0;
            4: return 4'h2;
            5: return 4'h3;
            default: return 4'h4;
        endcase
    endfunction

    // Drive one cycle of inputs (at negedge), advance the model, return at next negedge.
    task automatic cyc(input bit r, input bit rdy, input bit rv, input int ra);
        rst = r; out_ready = rdy; redirect_valid = rv; redirect_addr = ra[3:0];
        if (!r) begin
            m_pc = 0; m_v = 0; m_halt = 0; m_err = 0; m_opc = 0; m_word = '0;
        end else if (rv) begin
            m_v = 0; m_halt = 0;
            if (ra >= PL) begin m_pc = 0; m_err = 1; end
            else m_pc = ra;
        end else if (!m_halt && (!m_v || rdy)) begin
            m_word = mem[m_pc];
            m_opc  = m_pc;
            m_v    = 1;
`ifdef FETCH_ADDR_CHECK_EN
            if (int'(m_word[45:42]) != m_pc) m_err = 1;
`endif
            if (m_word[39:36] == 4'hF) m_halt = 1;
            m_pc = (m_pc + 1) % PL;
        end else if (m_v && rdy) begin
            m_v = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0);
        n_cmp++;
        if ({out_valid, addr, addr_err} !== 6'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got v=%b addr=%0d err=%b want 0/0/0", out_valid, addr, addr_err);
        end
        n_cmp++;
        if ({out_pc, out_mode, out_op, out_a, out_b, out_c} !== 46'd0) begin
            n_bad++; $display("FAIL reset_fields: got pc=%0d op=%0h a=%0h b=%0h c=%0h want all 0", out_pc, out_op, out_a, out_b, out_c);
        end
    endtask

    task automatic test_sequence();
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 4'(i % PL)) begin
                n_bad++; $display("FAIL seq_pc[%0d]: got v=%b pc=%0d want v=1 pc=%0d", i, out_valid, out_pc, i % PL);
            end
            n_cmp++;
            if ({out_mode, out_op, out_a, out_b, out_c} !== mem[i % PL][41:0]) begin
                n_bad++; $display("FAIL seq_word[%0d]: got op=%0h a=%0h want op=%0h a=%0h", i, out_op, out_a, mem[i % PL][39:36], mem[i % PL][35:24]);
            end
        end
    endtask

    task automatic test_stall();
        cyc(0, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0);
            n_cmp++;
            if (out_valid !== 1'b1 || out_pc !== 4'd2 || addr !== 4'd3 || out_op !== 4'h9) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got v=%b pc=%0d addr=%0d op=%0h want 1/2/3/9", k, out_valid, out_pc, addr, out_op);
            end
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd3) begin
            n_bad++; $display("FAIL stall_release: got v=%b pc=%0d want v=1 pc=3", out_valid, out_pc);
        end
    endtask

    task automatic test_redirect();
        cyc(0, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 5);
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== 4'd5) begin
            n_bad++; $display("FAIL redir_squash: got v=%b addr=%0d want v=0 addr=5", out_valid, addr);
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd5 || out_op !== 4'h3) begin
            n_bad++; $display("FAIL redir_target: got v=%b pc=%0d op=%0h want 1/5/3", out_valid, out_pc, out_op);
        end
    endtask

    task automatic test_halt();
        logic [45:0] save;
        save = mem[3];
        mem[3][39:36] = 4'hF;
        cyc(0, 0, 0, 0);
        repeat (4) cyc(1, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd3 || out_op !== 4'hF) begin
            n_bad++; $display("FAIL halt_present: got v=%b pc=%0d op=%0h want 1/3/f", out_valid, out_pc, out_op);
        end
        for (int k = 0; k < 11; k++) begin
            cyc(1, 1, 0, 0);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL halt_idle[%0d]: got v=%b want 0", k, out_valid);
            end
        end
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
            n_bad++; $display("FAIL halt_resume: got v=%b pc=%0d want v=1 pc=0", out_valid, out_pc);
        end
        mem[3] = save;
    endtask

    task automatic test_errors();
        logic [45:0] save;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 9);
        n_cmp++;
        if (addr !== 4'd0 || addr_err !== 1'b1) begin
            n_bad++; $display("FAIL err_oor: got addr=%0d err=%b want 0/1", addr, addr_err);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1'($urandom), 0, 0);
            n_cmp++;
            if (addr_err !== 1'b1) begin
                n_bad++; $display("FAIL err_sticky[%0d]: got %b want 1", k, addr_err);
            end
        end
        cyc(0, 0, 0, 0);
        n_cmp++;
        if (addr_err !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b want 0", addr_err);
        end
        save = mem[2];
        mem[2][45:42] = 4'hA;
        repeat (3) cyc(1, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd2 || out_op !== 4'h9) begin
            n_bad++; $display("FAIL echo_deliver: got v=%b pc=%0d op=%0h want 1/2/9", out_valid, out_pc, out_op);
        end
        n_cmp++;
`ifdef FETCH_ADDR_CHECK_EN
        if (addr_err !== 1'b1) begin
            n_bad++; $display("FAIL echo_err: got %b want 1", addr_err);
        end
`else
        if (addr_err !== 1'b0) begin
            n_bad++; $display("FAIL echo_err: got %b want 0", addr_err);
        end
`endif
        mem[2] = save;
    endtask

    task automatic test_reset_midstream();
        logic [45:0] save;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 1, 9);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 5);
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== 4'd0 || addr_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_stall: got v=%b addr=%0d err=%b want 0/0/0", out_valid, addr, addr_err);
        end
        save = mem[1];
        mem[1][39:36] = 4'hF;
        repeat (4) cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || addr !== 4'd0) begin
            n_bad++; $display("FAIL rst_halted: got v=%b addr=%0d want 0/0", out_valid, addr);
        end
        cyc(1, 1, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
            n_bad++; $display("FAIL rst_halted_run: got v=%b pc=%0d want 1/0", out_valid, out_pc);
        end
        mem[1] = save;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            mem[i] = mk(i, ($urandom % 10 == 0) ? 4'hF : 4'($urandom % 15));
            if ($urandom % 8 == 0) mem[i][45:42] = 4'($urandom);
        end
        cyc(0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 60) != 0, ($urandom % 4) != 0, ($urandom % 12) == 0, int'($urandom % 16));
            n_cmp++;
            if (out_valid !== m_v || addr_err !== m_err) begin
                n_bad++; $display("FAIL rnd_ctrl[%0d]: got v=%b err=%b want v=%b err=%b", n, out_valid, addr_err, m_v, m_err);
            end
            if (!m_halt) begin
                n_cmp++;
                if (addr !== 4'(m_pc)) begin
                    n_bad++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", n, addr, m_pc);
                end
            end
            if (m_v) begin
                n_cmp++;
                if (out_pc !== 4'(m_opc) || {out_mode, out_op, out_a, out_b, out_c} !== m_word[41:0]) begin
                    n_bad++; $display("FAIL rnd_word[%0d]: got pc=%0d op=%0h want pc=%0d op=%0h", n, out_pc, out_op, m_opc, m_word[39:36]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = mk(i, op_for(i));
        @(negedge clk);
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_halt();
        test_errors();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
